// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-requester data-memory arbiter with hold limit and burst lock
module dm_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              com_req,
  input  logic              com_lock,
  input  logic              com_wr_en,
  input  logic [ADDR_W-1:0] com_addr,
  input  logic [DATA_W-1:0] com_wdata,
  input  logic              proc_req,
  input  logic              proc_lock,
  input  logic              proc_wr_en,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic              com_ack,
  output logic              proc_ack,
  output logic              com_rvalid,
  output logic              proc_rvalid,
  output logic [1:0]        status,
  output logic [ADDR_W-1:0] DM_addr,
  output logic [DATA_W-1:0] DM_data_in,
  output logic              DM_write_en,
  input  logic [DATA_W-1:0] DM_data_out
);

  // State encoding doubles as the status code.
  typedef enum logic [1:0] {
    GNT_COM  = 2'b00,
    GNT_PROC = 2'b01,
    IDLE     = 2'b11
  } state_t;

  state_t     state, state_next;
  logic [7:0] hold_cnt;
  logic       last_proc;
  logic       hold_done;

  // The current access counts toward the limit, so the switch lands right after the last allowed ack.
  assign hold_done = ({1'b0, hold_cnt} + 9'd1) >= 9'(MAX_HOLD);
  assign status    = state;

  always_comb begin
    state_next  = state;
    com_ack     = 1'b0;
    proc_ack    = 1'b0;
    DM_addr     = '0;
    DM_data_in  = '0;
    DM_write_en = 1'b0;
    case (state)
      IDLE: begin
        if (com_req && proc_req) state_next = last_proc ? GNT_COM : GNT_PROC;
        else if (com_req)        state_next = GNT_COM;
        else if (proc_req)       state_next = GNT_PROC;
      end
      GNT_COM: begin
        if (com_req) begin
          com_ack     = 1'b1;
          DM_addr     = com_addr;
          DM_data_in  = com_wdata;
          DM_write_en = com_wr_en;
          if (!com_lock && proc_req && hold_done) state_next = GNT_PROC;
        end else begin
          state_next = proc_req ? GNT_PROC : IDLE;
        end
      end
      GNT_PROC: begin
        if (proc_req) begin
          proc_ack    = 1'b1;
          DM_addr     = proc_addr;
          DM_data_in  = proc_wdata;
          DM_write_en = proc_wr_en;
          if (!proc_lock && com_req && hold_done) state_next = GNT_COM;
        end else begin
          state_next = com_req ? GNT_COM : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_cnt    <= 8'd0;
      last_proc   <= 1'b1;
      com_rvalid  <= 1'b0;
      proc_rvalid <= 1'b0;
    end else begin
      state       <= state_next;
      com_rvalid  <= com_ack && !com_wr_en;
      proc_rvalid <= proc_ack && !proc_wr_en;
      if (state_next != state && state_next != IDLE) begin
        hold_cnt  <= 8'd0;
        last_proc <= (state_next == GNT_PROC);
      end else if ((com_ack || proc_ack) && hold_cnt != 8'hFF) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed self-checking bench for dm_arbiter
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        com_req, com_lock, com_wr_en;
  logic [15:0] com_addr, com_wdata;
  logic        proc_req, proc_lock, proc_wr_en;
  logic [15:0] proc_addr, proc_wdata;
  logic        com_ack, proc_ack, com_rvalid, proc_rvalid;
  logic [1:0]  status;
  logic [15:0] DM_addr, DM_data_in, DM_data_out;
  logic        DM_write_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.DATA_W(16), .ADDR_W(16), .MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .com_req(com_req), .com_lock(com_lock), .com_wr_en(com_wr_en),
    .com_addr(com_addr), .com_wdata(com_wdata),
    .proc_req(proc_req), .proc_lock(proc_lock), .proc_wr_en(proc_wr_en),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .com_ack(com_ack), .proc_ack(proc_ack),
    .com_rvalid(com_rvalid), .proc_rvalid(proc_rvalid),
    .status(status),
    .DM_addr(DM_addr), .DM_data_in(DM_data_in), .DM_write_en(DM_write_en),
    .DM_data_out(DM_data_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    com_req = 0; com_lock = 0; com_wr_en = 0; com_addr = 0; com_wdata = 0;
    proc_req = 0; proc_lock = 0; proc_wr_en = 0; proc_addr = 0; proc_wdata = 0;
    DM_data_out = 16'h0000;
    step();
    step();
    check("rst_status", 32'(status), 32'h3);
    check("rst_com_ack", 32'(com_ack), 32'h0);
    check("rst_proc_ack", 32'(proc_ack), 32'h0);
    check("rst_we", 32'(DM_write_en), 32'h0);
    check("rst_addr", 32'(DM_addr), 32'h0);
    check("rst_rvalid", 32'({com_rvalid, proc_rvalid}), 32'h0);

    // tie after reset: com wins, grant is registered
    rst_n = 1'b1;
    com_req = 1; proc_req = 1; com_addr = 16'h0010;
    #1;
    check("v1_idle_no_ack", 32'(com_ack), 32'h0);
    step();
    check("v1_status", 32'(status), 32'h0);
    check("v1_com_ack", 32'(com_ack), 32'h1);
    check("v1_proc_ack", 32'(proc_ack), 32'h0);
    check("v1_addr", 32'(DM_addr), 32'h0010);
    check("v1_we", 32'(DM_write_en), 32'h0);

    step();
    com_req = 0; DM_data_out = 16'hBEEF;
    #1;
    check("v2_com_rvalid", 32'(com_rvalid), 32'h1);
    check("v2_proc_rvalid", 32'(proc_rvalid), 32'h0);
    check("v2_data", 32'(DM_data_out), 32'hBEEF);
    check("v2_idle_addr", 32'(DM_addr), 32'h0);
    check("v2_no_ack", 32'(com_ack), 32'h0);
    step();
    check("v2_rvalid_pulse", 32'(com_rvalid), 32'h0);
    check("v2_handover", 32'(status), 32'h1);

    // proc write
    proc_wr_en = 1; proc_addr = 16'h0042; proc_wdata = 16'h1234;
    #1;
    check("v5_we", 32'(DM_write_en), 32'h1);
    check("v5_addr", 32'(DM_addr), 32'h0042);
    check("v5_data", 32'(DM_data_in), 32'h1234);
    check("v5_ack", 32'(proc_ack), 32'h1);
    step();
    proc_req = 0; proc_wr_en = 0;
    #1;
    check("v5_we_drop", 32'(DM_write_en), 32'h0);
    check("v5_no_rvalid", 32'(proc_rvalid), 32'h0);
    step();
    check("v5_idle", 32'(status), 32'h3);

    // hold limit: last served proc, so com wins and gets exactly 8 accesses
    com_req = 1; proc_req = 1; com_wr_en = 1;
    step();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("v3_status_%0d", i), 32'(status), 32'h0);
      check($sformatf("v3_ack_%0d", i), 32'(com_ack), 32'h1);
      step();
    end
    check("v3_switch", 32'(status), 32'h1);
    check("v3_com_ack_off", 32'(com_ack), 32'h0);
    check("v3_proc_ack", 32'(proc_ack), 32'h1);

    // locked burst of 20 exceeds the hold limit
    proc_req = 0;
    step();
    check("v4_to_com", 32'(status), 32'h0);
    proc_req = 1; com_lock = 1; com_wr_en = 0;
    #1;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("v4_ack_%0d", i), 32'({status, com_ack, proc_ack}), 32'b0010);
      step();
    end
    com_req = 0; com_lock = 0;
    #1;
    check("v4_drop_cycle", 32'({status, com_ack}), 32'b000);
    step();
    check("v4_proc_status", 32'(status), 32'h1);
    check("v4_proc_ack", 32'(proc_ack), 32'h1);

    // reset during a proc read
    proc_wr_en = 0; proc_addr = 16'h0007; rst_n = 0;
    #1;
    check("v6_ack_before", 32'(proc_ack), 32'h1);
    step();
    check("v6_status", 32'(status), 32'h3);
    check("v6_rvalid", 32'(proc_rvalid), 32'h0);
    check("v6_we", 32'(DM_write_en), 32'h0);
    check("v6_ack", 32'(proc_ack), 32'h0);
    rst_n = 1; com_req = 1; proc_req = 1;
    step();
    check("v6_tie_after_reset", 32'(status), 32'h0);
    check("v6_exclusive", 32'({com_ack, proc_ack}), 32'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
